hazard_stall_unit: RTL and testbench
====================================

// Module: hazard_stall_unit
// PURPOSE
//  Stall and flush controller for the 5-stage MIPS pipeline; it works alongside the forwarding unit.
//  Forwarding resolves hazards by bypass. This block resolves the ones bypass cannot:
//  load-use in EX and branch-compare-in-ID operand hazards. It also flushes IF/ID on taken branch/jump.
//  A small FSM holds multi-cycle stalls. Saturating counters report stall and flush activity.
// PARAMETERS
//  CNT_W  16  width of stall_cycles / flush_count counters
// PORTS
//  clk                 in   1      rising-edge clock
//  rst                 in   1      asynchronous reset, active-low (0 = reset)
//  IF_ID_rs            in   5      rs of instruction in ID
//  IF_ID_rt            in   5      rt of instruction in ID
//  IF_ID_uses_rt       in   1      ID instruction reads rt (R-type, beq/bne, sw)
//  ID_is_branch        in   1      beq/bne in ID (compare done in ID)
//  ID_branch_taken     in   1      ID comparator result, valid only when operands ready
//  ID_is_jump          in   1      j/jal/jr in ID
//  ID_EX_mem_read      in   1      lw in EX
//  ID_EX_reg_write_en  in   1      EX instruction writes a register
//  ID_EX_reg_dest      in   5      destination reg of EX instruction
//  EX_Mem_mem_read     in   1      lw in MEM
//  EX_Mem_rd           in   5      destination reg of MEM instruction
//  cnt_clear           in   1      synchronous clear of both counters
//  pc_write_en         out  1      PC may update
//  IF_ID_write_en      out  1      IF/ID register may update
//  IF_ID_flush         out  1      zero IF/ID on next edge
//  ID_EX_bubble        out  1      insert NOP into ID/EX on next edge
//  stall_cycles        out  CNT_W  saturating count of stall cycles
//  flush_count         out  CNT_W  saturating count of flushes
// BEHAVIOUR
//  match(r) = (r != 0) & (r == IF_ID_rs | (IF_ID_uses_rt & r == IF_ID_rt)). Register $0 never causes a hazard.
//  Hazard terms, evaluated combinationally in RUN only:
//   LU  = ID_EX_mem_read & match(ID_EX_reg_dest)
//   BA  = ID_is_branch & ID_EX_reg_write_en & ~ID_EX_mem_read & match(ID_EX_reg_dest)
//   BM  = ID_is_branch & EX_Mem_mem_read & match(EX_Mem_rd)
//   BL  = ID_is_branch & LU  (branch waits for lw in EX: 2 stall cycles)
//  FSM states: RUN, HOLD1.
//   RUN:   stall = LU|BA|BM. BL -> HOLD1; otherwise stay in RUN. Terms are re-evaluated every cycle.
//   HOLD1: stall = 1 unconditionally, no detection, always -> RUN.
//  While stall=1: pc_write_en=0, IF_ID_write_en=0, ID_EX_bubble=1, IF_ID_flush=0. Effect is same-cycle (combinational).
//  Flush: IF_ID_flush = RUN & ~stall & (ID_is_jump | (ID_is_branch & ID_branch_taken)).
//   On flush, pc_write_en=1 and IF_ID_write_en=1. The stall always wins, and the branch outcome is ignored while stalled.
//  Outputs otherwise: pc_write_en=1, IF_ID_write_en=1, IF_ID_flush=0, ID_EX_bubble=0.
//  Counters:
//   stall_cycles increments on every stall cycle. flush_count increments on every flush cycle.
//   Both saturate at all-ones; no wrap.
//   cnt_clear has priority over increment.
//  Reset (rst=0, asynchronous):
//   state=RUN, counters=0.
//   While rst=0: pc_write_en=0, IF_ID_write_en=0, IF_ID_flush=1, ID_EX_bubble=1.
//   Reset during HOLD1 aborts the hold. The first cycle after release is RUN with fresh detection.
//  Latency: the stall/flush decision is zero-cycle. Only the HOLD1 extension is registered (1 cycle).
// TESTING
//  lw $2 in EX, ID add $3,$2,$4 -> 1 cycle pc_write_en=0, ID_EX_bubble=1; next cycle all enables 1; stall_cycles=1.
//  lw $2 in EX, ID beq $2,$5 -> 2 stall cycles (RUN then HOLD1), then beq resolves; if taken, IF_ID_flush=1 on cycle 3.
//  add $7 in EX, ID bne $7,$0 -> 1 stall cycle; lw $7 in MEM with same bne -> 1 stall cycle; dest $0 -> no stall.
//  j in ID, no hazard -> IF_ID_flush=1 for 1 cycle, flush_count=1; taken beq during stall -> no flush until stall ends.
//  Preload stall_cycles near all-ones via repeated load-use -> holds at 16'hFFFF; cnt_clear with stall -> 0.
//  Assert rst=0 in HOLD1 -> outputs go to reset values immediately; after release, state RUN and counters 0.

Source files
------------

// File: rtl/hazard_stall_unit_if.sv
// Hazard unit pipeline bundle.
// Pipeline side drives hazard inputs; the unit drives enables/counters.
interface hazard_stall_unit_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       IF_ID_rs;
  logic [4:0]       IF_ID_rt;
  logic             IF_ID_uses_rt;
  logic             ID_is_branch;
  logic             ID_branch_taken;
  logic             ID_is_jump;
  logic             ID_EX_mem_read;
  logic             ID_EX_reg_write_en;
  logic [4:0]       ID_EX_reg_dest;
  logic             EX_Mem_mem_read;
  logic [4:0]       EX_Mem_rd;
  logic             cnt_clear;
  logic             pc_write_en;
  logic             IF_ID_write_en;
  logic             IF_ID_flush;
  logic             ID_EX_bubble;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output IF_ID_rs, IF_ID_rt, IF_ID_uses_rt,
    output ID_is_branch, ID_branch_taken, ID_is_jump,
    output ID_EX_mem_read, ID_EX_reg_write_en,
    output ID_EX_reg_dest,
    output EX_Mem_mem_read, EX_Mem_rd, cnt_clear,
    input  pc_write_en, IF_ID_write_en,
    input  IF_ID_flush, ID_EX_bubble,
    input  stall_cycles, flush_count
  );

  modport slave (
    input  IF_ID_rs, IF_ID_rt, IF_ID_uses_rt,
    input  ID_is_branch, ID_branch_taken, ID_is_jump,
    input  ID_EX_mem_read, ID_EX_reg_write_en,
    input  ID_EX_reg_dest,
    input  EX_Mem_mem_read, EX_Mem_rd, cnt_clear,
    output pc_write_en, IF_ID_write_en,
    output IF_ID_flush, ID_EX_bubble,
    output stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for hazards that bypass cannot resolve.
// Zero-cycle decisions; HOLD1 extends branch-on-load by one cycle.
module hazard_stall_unit #(
  parameter int CNT_W = 16
) (
  input logic                clk,
  input logic                rst,
  hazard_stall_unit_if.slave hz
);

  typedef enum logic {
    RUN   = 1'b0,
    HOLD1 = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic match_ex, match_mem;
  logic lu, ba, bm, bl;
  logic stall, flush;

  // Operand match against EX and MEM destinations ($0 never matches)
  always_comb begin
    match_ex = (hz.ID_EX_reg_dest != 5'd0) &&
               ((hz.ID_EX_reg_dest == hz.IF_ID_rs) ||
                (hz.IF_ID_uses_rt &&
                 hz.ID_EX_reg_dest == hz.IF_ID_rt));
    match_mem = (hz.EX_Mem_rd != 5'd0) &&
                ((hz.EX_Mem_rd == hz.IF_ID_rs) ||
                 (hz.IF_ID_uses_rt &&
                  hz.EX_Mem_rd == hz.IF_ID_rt));
  end

  // Hazard terms and the stall/flush decision
  always_comb begin
    lu = hz.ID_EX_mem_read & match_ex;
    ba = hz.ID_is_branch & hz.ID_EX_reg_write_en &
         ~hz.ID_EX_mem_read & match_ex;
    bm = hz.ID_is_branch & hz.EX_Mem_mem_read & match_mem;
    bl = hz.ID_is_branch & lu;
    stall = 1'b0;
    flush = 1'b0;
    unique case (state_q)
      RUN: begin
        stall = lu | ba | bm;
        flush = ~stall &
                (hz.ID_is_jump |
                 (hz.ID_is_branch & hz.ID_branch_taken));
      end
      HOLD1: stall = 1'b1;
      default: stall = 1'b1;
    endcase
  end

  // Pipeline enables; reset forces a flush/bubble posture
  always_comb begin
    hz.pc_write_en    = rst & ~stall;
    hz.IF_ID_write_en = rst & ~stall;
    hz.IF_ID_flush    = ~rst | flush;
    hz.ID_EX_bubble   = ~rst | stall;
    hz.stall_cycles   = stall_cnt_q;
    hz.flush_count    = flush_cnt_q;
  end

  // Next state: branch waiting on a load in EX holds one more cycle
  always_comb begin
    state_d = RUN;
    unique case (state_q)
      RUN:     state_d = bl ? HOLD1 : RUN;
      HOLD1:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Saturating activity counters, clear wins
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz.cnt_clear) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall && !(&stall_cnt_q))
        stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush && !(&flush_cnt_q))
        flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit.
// Directed pipeline scenarios then random traffic vs a rule model.
module tb_hazard_stall_unit;

  localparam int CW  = 8;
  localparam int MAX = (1 << CW) - 1;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       br;
    logic       taken;
    logic       jump;
    logic       ex_mr;
    logic       ex_we;
    logic [4:0] ex_rd;
    logic       mem_mr;
    logic [4:0] mem_rd;
    logic       clr;
  } stim_t;

  typedef struct {
    logic pc;
    logic ifid;
    logic fl;
    logic bub;
    int   sc;
    int   fc;
  } exp_t;

  logic clk;
  logic rst;
  exp_t q[$];
  int   passed;
  int   total;

  int  m_sc;
  int  m_fc;
  bit  m_hold;

  hazard_stall_unit_if #(.CNT_W(CW)) bus ();

  hazard_stall_unit #(.CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  function automatic bit uses(input stim_t s,
                              input logic [4:0] r);
    return (r != 0) &&
           (r == s.rs || (s.uses_rt && r == s.rt));
  endfunction

  task automatic chk(input string nm, input int act,
                     input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s actual=%0d required=%0d",
                  nm, act, req);
  endtask

  task automatic drive(input stim_t s);
    exp_t e;
    bit   stall, flush, load_use, blu;
    @(posedge clk);
    #1;
    rst                    = s.rst;
    bus.IF_ID_rs           = s.rs;
    bus.IF_ID_rt           = s.rt;
    bus.IF_ID_uses_rt      = s.uses_rt;
    bus.ID_is_branch       = s.br;
    bus.ID_branch_taken    = s.taken;
    bus.ID_is_jump         = s.jump;
    bus.ID_EX_mem_read     = s.ex_mr;
    bus.ID_EX_reg_write_en = s.ex_we;
    bus.ID_EX_reg_dest     = s.ex_rd;
    bus.EX_Mem_mem_read    = s.mem_mr;
    bus.EX_Mem_rd          = s.mem_rd;
    bus.cnt_clear          = s.clr;
    if (!s.rst) begin
      m_hold = 0;
      m_sc   = 0;
      m_fc   = 0;
      e = '{pc: 0, ifid: 0, fl: 1, bub: 1, sc: 0, fc: 0};
    end else begin
      load_use = s.ex_mr && uses(s, s.ex_rd);
      blu      = s.br && load_use;
      if (m_hold) stall = 1;
      else stall = load_use ||
                   (s.br && s.ex_we && !s.ex_mr &&
                    uses(s, s.ex_rd)) ||
                   (s.br && s.mem_mr && uses(s, s.mem_rd));
      flush = !m_hold && !stall &&
              (s.jump || (s.br && s.taken));
      e.pc   = !stall;
      e.ifid = !stall;
      e.fl   = flush;
      e.bub  = stall;
      e.sc   = m_sc;
      e.fc   = m_fc;
      if (s.clr) begin
        m_sc = 0;
        m_fc = 0;
      end else begin
        if (stall && m_sc < MAX) m_sc++;
        if (flush && m_fc < MAX) m_fc++;
      end
      m_hold = !m_hold && blu;
    end
    q.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("pc_write_en", int'(bus.pc_write_en), int'(e.pc));
        chk("IF_ID_write_en", int'(bus.IF_ID_write_en),
            int'(e.ifid));
        chk("IF_ID_flush", int'(bus.IF_ID_flush), int'(e.fl));
        chk("ID_EX_bubble", int'(bus.ID_EX_bubble),
            int'(e.bub));
        chk("stall_cycles", int'(bus.stall_cycles), e.sc);
        chk("flush_count", int'(bus.flush_count), e.fc);
      end
    end
  end

  initial begin
    stim_t s;
    passed = 0;
    total  = 0;
    m_sc   = 0;
    m_fc   = 0;
    m_hold = 0;
    s = idle();
    s.rst = 1'b0;
    rst = 1'b0;
    {bus.IF_ID_rs, bus.IF_ID_rt, bus.IF_ID_uses_rt,
     bus.ID_is_branch, bus.ID_branch_taken, bus.ID_is_jump,
     bus.ID_EX_mem_read, bus.ID_EX_reg_write_en,
     bus.ID_EX_reg_dest, bus.EX_Mem_mem_read, bus.EX_Mem_rd,
     bus.cnt_clear} = '0;
    drive(s);
    drive(s);
    // lw $2 in EX, add $3,$2,$4 in ID
    s = idle();
    s.rs = 5'd2; s.rt = 5'd4; s.uses_rt = 1;
    s.ex_mr = 1; s.ex_we = 1; s.ex_rd = 5'd2;
    drive(s);
    s = idle();
    s.rs = 5'd2; s.rt = 5'd4; s.uses_rt = 1;
    drive(s);
    // lw $2 in EX, beq $2,$5 taken
    s = idle();
    s.rs = 5'd2; s.rt = 5'd5; s.uses_rt = 1;
    s.br = 1; s.taken = 1;
    s.ex_mr = 1; s.ex_we = 1; s.ex_rd = 5'd2;
    drive(s);
    s.ex_mr = 0; s.ex_we = 0; s.ex_rd = 0;
    s.mem_mr = 1; s.mem_rd = 5'd2;
    drive(s);
    s.mem_mr = 0; s.mem_rd = 0;
    drive(s);
    // add $7 in EX, bne $7,$0
    s = idle();
    s.rs = 5'd7; s.rt = 5'd0; s.uses_rt = 1; s.br = 1;
    s.ex_we = 1; s.ex_rd = 5'd7;
    drive(s);
    s.ex_we = 0; s.ex_rd = 0;
    s.mem_mr = 1; s.mem_rd = 5'd7;
    drive(s);
    s.mem_mr = 0; s.mem_rd = 0;
    s.ex_we = 1; s.ex_mr = 1; s.ex_rd = 5'd0;
    drive(s);
    // jump, then idle
    s = idle();
    s.jump = 1;
    drive(s);
    drive(idle());
    // saturate stall counter with repeated load-use
    s = idle();
    s.rs = 5'd9; s.ex_mr = 1; s.ex_we = 1; s.ex_rd = 5'd9;
    repeat (MAX + 4) drive(s);
    s.clr = 1;
    drive(s);
    s.clr = 0;
    drive(s);
    // reset while in HOLD1
    s = idle();
    s.rs = 5'd3; s.br = 1; s.taken = 1;
    s.ex_mr = 1; s.ex_rd = 5'd3;
    drive(s);
    s.rst = 0;
    drive(s);
    s.rst = 1;
    s.ex_mr = 0;
    drive(s);
    drive(idle());
    // random traffic with small register space
    repeat (3000) begin
      s.rst     = ($urandom_range(0, 99) != 0);
      s.rs      = 5'($urandom_range(0, 3));
      s.rt      = 5'($urandom_range(0, 3));
      s.uses_rt = 1'($urandom);
      s.br      = 1'($urandom);
      s.taken   = 1'($urandom);
      s.jump    = ($urandom_range(0, 3) == 0);
      s.ex_mr   = 1'($urandom);
      s.ex_we   = 1'($urandom);
      s.ex_rd   = 5'($urandom_range(0, 3));
      s.mem_mr  = 1'($urandom);
      s.mem_rd  = 5'($urandom_range(0, 3));
      s.clr     = ($urandom_range(0, 49) == 0);
      drive(s);
    end
    drive(idle());
    for (int i = 0; i < 10 && q.size() != 0; i++)
      @(negedge clk);
    #2;
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
